// File: rtl/mem_access_controller_if.sv
// mem_access_controller_if: req/ack data-memory port between the MEM-stage controller and the data memory
interface mem_access_controller_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  dmem_req;
   logic                  dmem_we;
   logic [DATA_WIDTH-1:0] dmem_addr;
   logic [DATA_WIDTH-1:0] dmem_wdata;
   logic                  dmem_ack;
   logic [DATA_WIDTH-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_access_controller.sv
// mem_access_controller: sequences the EX/MEM data-memory access, stalls the pipeline until it completes, flags timeouts
module mem_access_controller #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    mem_valid_i,
   input  logic                    mem_shouldReadMemory_i,
   input  logic                    mem_shouldWriteMemory_i,
   input  logic [DATA_WIDTH-1:0]   mem_aluOutput_i,
   input  logic [DATA_WIDTH-1:0]   mem_registerRtOrZero_i,
   mem_access_controller_if.master dmem,
   output logic                    pipeline_stall_o,
   output logic [DATA_WIDTH-1:0]   mem_loadData_o,
   output logic                    mem_accessDone_o,
   output logic                    mem_error_o
);
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, REQ, DONE, ERROR} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] load_q, load_d;
   logic                  access_req;

   assign access_req = mem_valid_i & (mem_shouldReadMemory_i | mem_shouldWriteMemory_i);

   // State, timeout counter and latched request/load registers; all clear on reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         load_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         load_q  <= load_d;
      end
   end

   // Next state: latch the request in IDLE, wait for ack or timeout in REQ; ERROR only leaves on reset
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      load_d  = load_q;
      case (state_q)
         IDLE: begin
            if (access_req) begin
               state_d = REQ;
               cnt_d   = '0;
               we_d    = mem_shouldWriteMemory_i;
               addr_d  = mem_aluOutput_i;
               wdata_d = mem_registerRtOrZero_i;
            end
         end
         REQ: begin
            if (dmem.dmem_ack) begin
               state_d = DONE;
               load_d  = we_q ? load_q : dmem.dmem_rdata;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == LAST) begin
               state_d = ERROR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:  state_d = IDLE;
         ERROR: state_d = ERROR;
      endcase
   end

   assign dmem.dmem_req    = state_q == REQ;
   assign dmem.dmem_we     = we_q;
   assign dmem.dmem_addr   = addr_q;
   assign dmem.dmem_wdata  = wdata_q;
   assign pipeline_stall_o = (state_q == IDLE && access_req) || state_q == REQ || state_q == ERROR;
   assign mem_loadData_o   = load_q;
   assign mem_accessDone_o = state_q == DONE;
   assign mem_error_o      = state_q == ERROR;
endmodule

// File: tb/tb_mem_access_controller.sv
// tb_mem_access_controller: cycle-by-cycle vector check of the MEM-stage access controller
module tb_mem_access_controller;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        v = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic        stall, done, err;
   logic [31:0] ld;
   int          n = 0, fails = 0, idx = 0;

   typedef struct {
      logic        rst, v, rd, wr;
      logic [31:0] addr, wdata;
      logic        ack;
      logic [31:0] rdata;
      logic        e_req, e_we;
      logic [31:0] e_addr, e_wdata;
      logic        e_stall, e_done, e_err;
      logic [31:0] e_ld;
   } vec_t;

   vec_t tbl[$];

   mem_access_controller_if #(.DATA_WIDTH(32)) dif();

   mem_access_controller #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .mem_valid_i            (v),
      .mem_shouldReadMemory_i (rd),
      .mem_shouldWriteMemory_i(wr),
      .mem_aluOutput_i        (addr),
      .mem_registerRtOrZero_i (wdata),
      .dmem                   (dif.master),
      .pipeline_stall_o       (stall),
      .mem_loadData_o         (ld),
      .mem_accessDone_o       (done),
      .mem_error_o            (err)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(logic rst_, v_, rd_, wr_, logic [31:0] a_, wd_, logic ack_, logic [31:0] rdat_,
                               logic rq_, we_, logic [31:0] ea_, ewd_, logic st_, dn_, er_, logic [31:0] ld_);
      vec_t t;
      t.rst = rst_; t.v = v_; t.rd = rd_; t.wr = wr_; t.addr = a_; t.wdata = wd_; t.ack = ack_; t.rdata = rdat_;
      t.e_req = rq_; t.e_we = we_; t.e_addr = ea_; t.e_wdata = ewd_;
      t.e_stall = st_; t.e_done = dn_; t.e_err = er_; t.e_ld = ld_;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n++;
      if (act !== exp) begin
         fails++;
         $display("FAIL vec %0d %s: got %h expected %h", idx, nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t t);
      reset = t.rst; v = t.v; rd = t.rd; wr = t.wr; addr = t.addr; wdata = t.wdata;
      dif.dmem_ack = t.ack; dif.dmem_rdata = t.rdata;
      @(negedge clock);
      chk("req", 32'(dif.dmem_req), 32'(t.e_req));
      chk("stall", 32'(stall), 32'(t.e_stall));
      chk("done", 32'(done), 32'(t.e_done));
      chk("error", 32'(err), 32'(t.e_err));
      chk("loadData", ld, t.e_ld);
      if (t.e_req) begin
         chk("we", 32'(dif.dmem_we), 32'(t.e_we));
         chk("addr", dif.dmem_addr, t.e_addr);
         if (t.e_we) chk("wdata", dif.dmem_wdata, t.e_wdata);
      end
      @(posedge clock);
      #1;
      idx++;
   endtask

   initial begin
      dif.dmem_ack = 1'b0;
      dif.dmem_rdata = '0;
      // reset state
      tbl.push_back(mk(1,0,0,0, 0,0, 0,0,                        0,0,0,0, 0,0,0,0));
      // load 0x100, immediate ack
      tbl.push_back(mk(0,1,1,0, 32'h100,0, 0,0,                  0,0,0,0, 1,0,0,0));
      tbl.push_back(mk(0,1,1,0, 32'h100,0, 1,32'hDEADBEEF,       1,0,32'h100,0, 1,0,0,0));
      tbl.push_back(mk(0,1,1,0, 32'h100,0, 0,0,                  0,0,0,0, 0,1,0,32'hDEADBEEF));
      tbl.push_back(mk(0,0,0,0, 0,0, 0,0,                        0,0,0,0, 0,0,0,32'hDEADBEEF));
      // store 0x40, ack on 4th REQ cycle; inputs wobble mid-request to prove latching
      tbl.push_back(mk(0,1,0,1, 32'h40,32'h12345678, 0,0,        0,0,0,0, 1,0,0,32'hDEADBEEF));
      tbl.push_back(mk(0,1,0,1, 32'h40,32'h12345678, 0,0,        1,1,32'h40,32'h12345678, 1,0,0,32'hDEADBEEF));
      tbl.push_back(mk(0,1,0,1, 32'h999,0, 0,0,                  1,1,32'h40,32'h12345678, 1,0,0,32'hDEADBEEF));
      tbl.push_back(mk(0,1,0,1, 32'h40,32'h12345678, 0,0,        1,1,32'h40,32'h12345678, 1,0,0,32'hDEADBEEF));
      tbl.push_back(mk(0,1,0,1, 32'h40,32'h12345678, 1,32'hFFFFFFFF, 1,1,32'h40,32'h12345678, 1,0,0,32'hDEADBEEF));
      tbl.push_back(mk(0,1,0,1, 32'h40,32'h12345678, 0,0,        0,0,0,0, 0,1,0,32'hDEADBEEF));
      tbl.push_back(mk(0,0,0,0, 0,0, 0,0,                        0,0,0,0, 0,0,0,32'hDEADBEEF));
      // back-to-back loads
      tbl.push_back(mk(0,1,1,0, 32'h10,0, 0,0,                   0,0,0,0, 1,0,0,32'hDEADBEEF));
      tbl.push_back(mk(0,1,1,0, 32'h10,0, 1,32'hA,               1,0,32'h10,0, 1,0,0,32'hDEADBEEF));
      tbl.push_back(mk(0,1,1,0, 32'h10,0, 0,0,                   0,0,0,0, 0,1,0,32'hA));
      tbl.push_back(mk(0,1,1,0, 32'h14,0, 0,0,                   0,0,0,0, 1,0,0,32'hA));
      tbl.push_back(mk(0,1,1,0, 32'h14,0, 1,32'hB,               1,0,32'h14,0, 1,0,0,32'hA));
      tbl.push_back(mk(0,1,1,0, 32'h14,0, 0,0,                   0,0,0,0, 0,1,0,32'hB));
      tbl.push_back(mk(0,0,0,0, 0,0, 0,0,                        0,0,0,0, 0,0,0,32'hB));
      // invalid store plus spurious ack in IDLE
      tbl.push_back(mk(0,0,0,1, 32'h80,32'h5, 1,32'h55,          0,0,0,0, 0,0,0,32'hB));
      tbl.push_back(mk(0,0,0,1, 32'h80,32'h5, 1,32'h55,          0,0,0,0, 0,0,0,32'hB));
      // read and write both set: store wins, load data untouched
      tbl.push_back(mk(0,1,1,1, 32'h20,32'h77, 0,0,              0,0,0,0, 1,0,0,32'hB));
      tbl.push_back(mk(0,1,1,1, 32'h20,32'h77, 1,32'h99,         1,1,32'h20,32'h77, 1,0,0,32'hB));
      tbl.push_back(mk(0,1,1,1, 32'h20,32'h77, 0,0,              0,0,0,0, 0,1,0,32'hB));
      tbl.push_back(mk(0,0,0,0, 0,0, 0,0,                        0,0,0,0, 0,0,0,32'hB));

      repeat (2) @(posedge clock);
      #1;
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // timeout: four unanswered REQ cycles, then sticky ERROR until reset
      apply(mk(0,1,1,0, 32'h200,0, 0,0, 0,0,0,0, 1,0,0,32'hB));
      for (int i = 0; i < 4; i++) apply(mk(0,1,1,0, 32'h200,0, 0,0, 1,0,32'h200,0, 1,0,0,32'hB));
      apply(mk(0,1,1,0, 32'h200,0, 0,0, 0,0,0,0, 1,0,1,32'hB));
      apply(mk(0,0,0,0, 0,0, 1,32'h1, 0,0,0,0, 1,0,1,32'hB));
      apply(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0, 1,0,1,32'hB));
      apply(mk(1,0,0,0, 0,0, 0,0, 0,0,0,0, 1,0,1,32'hB));
      apply(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0,0));

      // reset in the second REQ cycle drops the request; a later ack is ignored
      apply(mk(0,1,1,0, 32'h300,0, 0,0, 0,0,0,0, 1,0,0,0));
      apply(mk(0,1,1,0, 32'h300,0, 0,0, 1,0,32'h300,0, 1,0,0,0));
      apply(mk(1,1,1,0, 32'h300,0, 0,0, 1,0,32'h300,0, 1,0,0,0));
      apply(mk(0,0,0,0, 0,0, 1,32'h1234, 0,0,0,0, 0,0,0,0));
      apply(mk(0,0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0,0));

      $display("== %0d vectors applied, %0d miscompares ==", n, fails);
      $finish;
   end
endmodule
